// File: rtl/axi_lite_arbiter.sv
// Two-requester AXI-Lite arbiter: one whole transaction at a time on the
// shared master port, round-robin between s0 and s1.
module axi_lite_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter bit WRITE_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    output logic [1:0]              s0_bresp,
    output logic                    s0_bvalid,
    input  logic                    s0_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr,
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    output logic [1:0]              s0_rresp,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    output logic [1:0]              s1_bresp,
    output logic                    s1_bvalid,
    input  logic                    s1_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr,
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    output logic [1:0]              s1_rresp,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic [1:0]              grant,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t state;
    logic   owner;
    logic   rr_ptr;
    logic   ar_done;
    logic   aw_done;
    logic   w_done;

    logic req0, req1, pick, pick_aw, pick_ar, go_wr;
    logic rd, wr;
    logic sel_arvalid, sel_awvalid, sel_wvalid, sel_rready, sel_bready;

    assign req0    = s0_arvalid | s0_awvalid;
    assign req1    = s1_arvalid | s1_awvalid;
    assign pick    = (req0 & req1) ? rr_ptr : req1;
    assign pick_aw = pick ? s1_awvalid : s0_awvalid;
    assign pick_ar = pick ? s1_arvalid : s0_arvalid;
    assign go_wr   = pick_aw & (WRITE_FIRST | ~pick_ar);

    assign rd = (state == RD);
    assign wr = (state == WR);

    assign sel_arvalid = owner ? s1_arvalid : s0_arvalid;
    assign sel_awvalid = owner ? s1_awvalid : s0_awvalid;
    assign sel_wvalid  = owner ? s1_wvalid  : s0_wvalid;
    assign sel_rready  = owner ? s1_rready  : s0_rready;
    assign sel_bready  = owner ? s1_bready  : s0_bready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            rr_ptr  <= 1'b0;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            grant   <= 2'b00;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        owner   <= pick;
                        state   <= go_wr ? WR : RD;
                        grant   <= pick ? 2'b10 : 2'b01;
                        busy    <= 1'b1;
                        ar_done <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                RD: begin
                    if (m_arvalid & m_arready)
                        ar_done <= 1'b1;
                    if (m_rvalid & m_rready) begin
                        state  <= IDLE;
                        rr_ptr <= ~owner;
                        grant  <= 2'b00;
                        busy   <= 1'b0;
                    end
                end
                WR: begin
                    if (m_awvalid & m_awready)
                        aw_done <= 1'b1;
                    if (m_wvalid & m_wready)
                        w_done <= 1'b1;
                    if (m_bvalid & m_bready) begin
                        state  <= IDLE;
                        rr_ptr <= ~owner;
                        grant  <= 2'b00;
                        busy   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // done flags keep a single address/data beat in flight per grant
    assign m_arvalid = rd & ~ar_done & sel_arvalid;
    assign m_araddr  = owner ? s1_araddr : s0_araddr;
    assign m_rready  = rd & sel_rready;

    assign s0_arready = rd & ~owner & ~ar_done & m_arready;
    assign s1_arready = rd &  owner & ~ar_done & m_arready;
    assign s0_rvalid  = rd & ~owner & m_rvalid;
    assign s1_rvalid  = rd &  owner & m_rvalid;
    assign s0_rdata   = m_rdata;
    assign s1_rdata   = m_rdata;
    assign s0_rresp   = m_rresp;
    assign s1_rresp   = m_rresp;

    assign m_awvalid = wr & ~aw_done & sel_awvalid;
    assign m_awaddr  = owner ? s1_awaddr : s0_awaddr;
    assign m_wvalid  = wr & ~w_done & sel_wvalid;
    assign m_wdata   = owner ? s1_wdata : s0_wdata;
    assign m_wstrb   = owner ? s1_wstrb : s0_wstrb;
    assign m_bready  = wr & sel_bready;

    assign s0_awready = wr & ~owner & ~aw_done & m_awready;
    assign s1_awready = wr &  owner & ~aw_done & m_awready;
    assign s0_wready  = wr & ~owner & ~w_done & m_wready;
    assign s1_wready  = wr &  owner & ~w_done & m_wready;
    assign s0_bvalid  = wr & ~owner & m_bvalid;
    assign s1_bvalid  = wr &  owner & m_bvalid;
    assign s0_bresp   = m_bresp;
    assign s1_bresp   = m_bresp;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed vector table, hand sequences for contention/reset corners,
// and a randomized run with a slave model and fairness bound.
module tb_axi_lite_arbiter;

    logic clk, rst;

    logic [31:0] s_awaddr[2], s_wdata[2], s_araddr[2], s_rdata[2];
    logic [3:0]  s_wstrb[2];
    logic [1:0]  s_bresp[2], s_rresp[2];
    logic s_awvalid[2], s_awready[2], s_wvalid[2], s_wready[2];
    logic s_bvalid[2], s_bready[2], s_arvalid[2], s_arready[2];
    logic s_rvalid[2], s_rready[2];

    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp, grant;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready, busy;

    logic [31:0] x_rdata[2], x_m_awaddr, x_m_wdata, x_m_araddr;
    logic [3:0]  x_m_wstrb;
    logic [1:0]  x_bresp[2], x_rresp[2], x_grant;
    logic x_awready[2], x_wready[2], x_bvalid[2], x_arready[2], x_rvalid[2];
    logic x_m_awvalid, x_m_wvalid, x_m_bready, x_m_arvalid, x_m_rready, x_busy;

    int n_chk = 0;
    int n_err = 0;

    axi_lite_arbiter #(.WRITE_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .s0_awaddr(s_awaddr[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]),
        .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wvalid(s_wvalid[0]),
        .s0_wready(s_wready[0]), .s0_bresp(s_bresp[0]), .s0_bvalid(s_bvalid[0]),
        .s0_bready(s_bready[0]), .s0_araddr(s_araddr[0]), .s0_arvalid(s_arvalid[0]),
        .s0_arready(s_arready[0]), .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]),
        .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
        .s1_awaddr(s_awaddr[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]),
        .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wvalid(s_wvalid[1]),
        .s1_wready(s_wready[1]), .s1_bresp(s_bresp[1]), .s1_bvalid(s_bvalid[1]),
        .s1_bready(s_bready[1]), .s1_araddr(s_araddr[1]), .s1_arvalid(s_arvalid[1]),
        .s1_arready(s_arready[1]), .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]),
        .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .grant(grant), .busy(busy)
    );

    axi_lite_arbiter #(.WRITE_FIRST(1'b0)) dut_rf (
        .clk(clk), .rst(rst),
        .s0_awaddr(s_awaddr[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(x_awready[0]),
        .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wvalid(s_wvalid[0]),
        .s0_wready(x_wready[0]), .s0_bresp(x_bresp[0]), .s0_bvalid(x_bvalid[0]),
        .s0_bready(s_bready[0]), .s0_araddr(s_araddr[0]), .s0_arvalid(s_arvalid[0]),
        .s0_arready(x_arready[0]), .s0_rdata(x_rdata[0]), .s0_rresp(x_rresp[0]),
        .s0_rvalid(x_rvalid[0]), .s0_rready(s_rready[0]),
        .s1_awaddr(s_awaddr[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(x_awready[1]),
        .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wvalid(s_wvalid[1]),
        .s1_wready(x_wready[1]), .s1_bresp(x_bresp[1]), .s1_bvalid(x_bvalid[1]),
        .s1_bready(s_bready[1]), .s1_araddr(s_araddr[1]), .s1_arvalid(s_arvalid[1]),
        .s1_arready(x_arready[1]), .s1_rdata(x_rdata[1]), .s1_rresp(x_rresp[1]),
        .s1_rvalid(x_rvalid[1]), .s1_rready(s_rready[1]),
        .m_awaddr(x_m_awaddr), .m_awvalid(x_m_awvalid), .m_awready(m_awready),
        .m_wdata(x_m_wdata), .m_wstrb(x_m_wstrb), .m_wvalid(x_m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(x_m_bready),
        .m_araddr(x_m_araddr), .m_arvalid(x_m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(x_m_rready),
        .grant(x_grant), .busy(x_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          who;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [1:0]  exp_grant;
        bit          other_rd;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_awvalid[i] = 0; s_wvalid[i] = 0; s_arvalid[i] = 0;
            s_awaddr[i] = '0; s_wdata[i] = '0; s_wstrb[i] = '0; s_araddr[i] = '0;
            s_bready[i] = 1; s_rready[i] = 1;
        end
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
        step(); step();
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_m_valids", {m_arvalid, m_awvalid, m_wvalid}, 3'b000);
        chk("rst_m_readies", {m_bready, m_rready}, 2'b00);
        rst = 1'b0;
        step();
    endtask

    task automatic finish_read(input int who, input logic [31:0] rdata);
        int o;
        o = 1 - who;
        chk("fr_m_arvalid", m_arvalid, 1);
        chk("fr_m_araddr", m_araddr, s_araddr[who]);
        m_arready = 1;
        #1;
        chk("fr_s_arready", s_arready[who], 1);
        chk("fr_other_arready", s_arready[o], 0);
        step();
        s_arvalid[who] = 0; m_arready = 0;
        m_rvalid = 1; m_rdata = rdata; m_rresp = 2'b00;
        #1;
        chk("fr_s_rvalid", s_rvalid[who], 1);
        chk("fr_s_rdata", s_rdata[who], rdata);
        chk("fr_other_rvalid", s_rvalid[o], 0);
        step();
        m_rvalid = 0;
        #1;
        chk("fr_idle_grant", grant, 2'b00);
    endtask

    task automatic do_txn(input vec_t v);
        int w, o;
        w = v.who;
        o = 1 - w;
        if (v.wr) begin
            s_awvalid[w] = 1; s_awaddr[w] = v.addr;
            s_wvalid[w] = 1; s_wdata[w] = v.data; s_wstrb[w] = v.strb;
        end else begin
            s_arvalid[w] = 1; s_araddr[w] = v.addr;
        end
        step();
        if (v.other_rd) begin
            s_arvalid[o] = 1; s_araddr[o] = 32'h0000_0F00;
        end
        #1;
        chk("tx_grant", grant, v.exp_grant);
        chk("tx_busy", busy, 1);
        if (v.wr) begin
            chk("tx_m_awvalid", m_awvalid, 1);
            chk("tx_m_awaddr", m_awaddr, v.addr);
            chk("tx_m_wvalid", m_wvalid, 1);
            chk("tx_m_wdata", m_wdata, v.data);
            chk("tx_m_wstrb", m_wstrb, v.strb);
            chk("tx_m_arvalid", m_arvalid, 0);
            m_wready = 1; m_arready = 1;
            #1;
            chk("tx_s_wready", s_wready[w], 1);
            chk("tx_s_awready", s_awready[w], 0);
            if (v.other_rd) chk("tx_stall_arready", s_arready[o], 0);
            step();
            s_wvalid[w] = 0; m_wready = 0; m_arready = 0; m_awready = 1;
            #1;
            chk("tx_w_once", m_wvalid, 0);
            chk("tx_s_awready2", s_awready[w], 1);
            step();
            s_awvalid[w] = 0; m_awready = 0; m_bvalid = 1; m_bresp = v.resp;
            #1;
            chk("tx_s_bvalid", s_bvalid[w], 1);
            chk("tx_s_bresp", s_bresp[w], v.resp);
            chk("tx_other_bvalid", s_bvalid[o], 0);
            chk("tx_m_bready", m_bready, 1);
            step();
            m_bvalid = 0;
        end else begin
            chk("tx_m_arvalid", m_arvalid, 1);
            chk("tx_m_araddr", m_araddr, v.addr);
            chk("tx_m_awvalid", m_awvalid, 0);
            m_arready = 1;
            #1;
            chk("tx_s_arready", s_arready[w], 1);
            if (v.other_rd) chk("tx_stall_arready", s_arready[o], 0);
            step();
            s_arvalid[w] = 0; m_arready = 0;
            m_rvalid = 1; m_rdata = v.data; m_rresp = v.resp;
            #1;
            chk("tx_s_rvalid", s_rvalid[w], 1);
            chk("tx_s_rdata", s_rdata[w], v.data);
            chk("tx_s_rresp", s_rresp[w], v.resp);
            chk("tx_m_rready", m_rready, 1);
            step();
            m_rvalid = 0;
        end
        #1;
        chk("tx_end_grant", grant, 2'b00);
        chk("tx_end_busy", busy, 0);
    endtask

    logic [31:0] q_addr[2], q_data[2];
    logic [3:0]  q_strb[2];
    bit          q_act[2], q_wr[2];
    int          q_wait[2];
    logic [31:0] cap_ar, cap_aw, cap_w;
    logic [3:0]  cap_s;
    bit          r_pend, aw_got, w_got;
    bit          f_ar, f_aw, f_w, f_r, f_b;
    bit          c_ar[2], c_aw[2], c_w[2], c_fin[2];
    int          n_done;

    initial begin
        vecs[0] = '{0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'h0, 2'd0, 2'b01, 1'b0};
        vecs[1] = '{1, 1'b0, 32'h0000_2000, 32'hCAFE_F00D, 4'h0, 2'd2, 2'b10, 1'b0};
        vecs[2] = '{1, 1'b1, 32'h0000_2004, 32'h1234_5678, 4'h3, 2'd0, 2'b10, 1'b1};
        vecs[3] = '{0, 1'b1, 32'h0000_3000, 32'hAABB_CCDD, 4'hF, 2'd1, 2'b01, 1'b0};
        vecs[4] = '{0, 1'b0, 32'h0000_4008, 32'h0BAD_CAFE, 4'h0, 2'd3, 2'b01, 1'b1};

        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_txn(vecs[i]);
            if (vecs[i].other_rd) begin
                step();
                chk("stalled_grant", grant, (vecs[i].who == 0) ? 2'b10 : 2'b01);
                finish_read(1 - vecs[i].who, 32'h600D_0000 + i);
            end
        end

        // simultaneous reads, then alternation once rr_ptr points at s1
        do_reset();
        s_arvalid[0] = 1; s_araddr[0] = 32'h100;
        s_arvalid[1] = 1; s_araddr[1] = 32'h200;
        step();
        chk("rr_first", grant, 2'b01);
        finish_read(0, 32'h1111_0000);
        step();
        chk("rr_second", grant, 2'b10);
        finish_read(1, 32'h2222_0000);
        s_arvalid[0] = 1;
        step();
        chk("rr_solo", grant, 2'b01);
        finish_read(0, 32'h3333_0000);
        s_arvalid[0] = 1; s_arvalid[1] = 1;
        step();
        chk("rr_alt_first", grant, 2'b10);
        finish_read(1, 32'h4444_0000);
        step();
        chk("rr_alt_second", grant, 2'b01);
        finish_read(0, 32'h5555_0000);

        // aw and ar together from one requester
        do_reset();
        s_awvalid[0] = 1; s_awaddr[0] = 32'h40;
        s_wvalid[0] = 1; s_wdata[0] = 32'h55; s_wstrb[0] = 4'hF;
        s_arvalid[0] = 1; s_araddr[0] = 32'h80;
        step();
        chk("wf1_awvalid", m_awvalid, 1);
        chk("wf1_arvalid", m_arvalid, 0);
        chk("wf0_arvalid", x_m_arvalid, 1);
        chk("wf0_awvalid", x_m_awvalid, 0);
        m_awready = 1; m_wready = 1;
        step();
        s_awvalid[0] = 0; s_wvalid[0] = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 1;
        #1;
        chk("wf1_bvalid", s_bvalid[0], 1);
        chk("wf1_rd_held", m_arvalid, 0);
        step();
        m_bvalid = 0;
        #1;
        chk("wf1_bubble", grant, 2'b00);
        step();
        chk("wf1_rd_grant", grant, 2'b01);
        finish_read(0, 32'h7777_0000);

        // reset in the middle of a read; rr_ptr must return to s0
        do_reset();
        s_arvalid[0] = 1; s_araddr[0] = 32'h500;
        step();
        finish_read(0, 32'h8888_0000);
        s_arvalid[0] = 1;
        step();
        chk("mr_pre_arvalid", m_arvalid, 1);
        rst = 1;
        #1;
        chk("mr_grant", grant, 2'b00);
        chk("mr_busy", busy, 0);
        chk("mr_arvalid", m_arvalid, 0);
        chk("mr_rready", m_rready, 0);
        s_arvalid[0] = 0;
        step();
        rst = 0;
        m_rvalid = 1; m_rdata = 32'hBAD0_BAD0;
        #1;
        chk("mr_late_rvalid", s_rvalid[0], 0);
        step();
        chk("mr_late_rvalid2", s_rvalid[0], 0);
        chk("mr_idle", grant, 2'b00);
        m_rvalid = 0;
        s_arvalid[0] = 1; s_arvalid[1] = 1;
        step();
        chk("mr_rr_reset", grant, 2'b01);
        finish_read(0, 32'h9999_0000);
        step();
        finish_read(1, 32'hAAAA_0000);

        // randomized traffic with a responsive slave model
        do_reset();
        for (int i = 0; i < 2; i++) begin
            q_act[i] = 0; q_wr[i] = 0; q_wait[i] = 0;
            q_addr[i] = 0; q_data[i] = 0; q_strb[i] = 0;
        end
        r_pend = 0; aw_got = 0; w_got = 0;
        cap_ar = 0; cap_aw = 0; cap_w = 0; cap_s = 0;
        n_done = 0;
        for (int cyc = 0; cyc < 20000 && n_done < 300; cyc++) begin
            #1;
            f_ar = m_arvalid && m_arready;
            f_aw = m_awvalid && m_awready;
            f_w  = m_wvalid && m_wready;
            f_r  = m_rvalid && m_rready;
            f_b  = m_bvalid && m_bready;
            if (f_ar) cap_ar = m_araddr;
            if (f_aw) cap_aw = m_awaddr;
            if (f_w) begin
                cap_w = m_wdata; cap_s = m_wstrb;
            end
            for (int i = 0; i < 2; i++) begin
                c_ar[i] = s_arvalid[i] && s_arready[i];
                c_aw[i] = s_awvalid[i] && s_awready[i];
                c_w[i]  = s_wvalid[i] && s_wready[i];
                c_fin[i] = 0;
                if (s_rvalid[i]) begin
                    c_fin[i] = 1;
                    chk("rnd_r_kind", {q_act[i], q_wr[i]}, 2'b10);
                    chk("rnd_rdata", s_rdata[i], q_addr[i] ^ 32'h5A5A_0F0F);
                    chk("rnd_rresp", s_rresp[i], q_addr[i][5:4]);
                end
                if (s_bvalid[i]) begin
                    c_fin[i] = 1;
                    chk("rnd_b_kind", {q_act[i], q_wr[i]}, 2'b11);
                    chk("rnd_awaddr", cap_aw, q_addr[i]);
                    chk("rnd_wdata", cap_w, q_data[i]);
                    chk("rnd_wstrb", cap_s, q_strb[i]);
                    chk("rnd_bresp", s_bresp[i], q_addr[i][3:2]);
                end
                if (c_fin[i]) chk("rnd_starve", q_wait[i] <= 1, 1);
            end
            for (int i = 0; i < 2; i++)
                if (c_fin[i] && q_act[1-i]) q_wait[1-i]++;
            step();
            for (int i = 0; i < 2; i++) begin
                if (c_ar[i]) s_arvalid[i] = 0;
                if (c_aw[i]) s_awvalid[i] = 0;
                if (c_w[i]) s_wvalid[i] = 0;
                if (c_fin[i]) begin
                    q_act[i] = 0;
                    n_done++;
                end
            end
            if (f_r) begin
                m_rvalid = 0; r_pend = 0;
            end
            if (f_ar) r_pend = 1;
            if (f_b) begin
                m_bvalid = 0; aw_got = 0; w_got = 0;
            end
            if (f_aw) aw_got = 1;
            if (f_w) w_got = 1;
            if (r_pend && !m_rvalid && $urandom_range(0, 1) == 1) begin
                m_rvalid = 1; m_rdata = cap_ar ^ 32'h5A5A_0F0F; m_rresp = cap_ar[5:4];
            end
            if (aw_got && w_got && !m_bvalid && $urandom_range(0, 1) == 1) begin
                m_bvalid = 1; m_bresp = cap_aw[3:2];
            end
            m_arready = 1'($urandom_range(0, 1));
            m_awready = 1'($urandom_range(0, 1));
            m_wready  = 1'($urandom_range(0, 1));
            for (int i = 0; i < 2; i++) begin
                if (!q_act[i] && $urandom_range(0, 2) != 0) begin
                    q_act[i] = 1;
                    q_wait[i] = 0;
                    q_wr[i] = 1'($urandom_range(0, 1));
                    q_addr[i] = $urandom;
                    q_data[i] = $urandom;
                    q_strb[i] = 4'($urandom);
                    if (q_wr[i]) begin
                        s_awvalid[i] = 1; s_awaddr[i] = q_addr[i];
                        s_wvalid[i] = 1; s_wdata[i] = q_data[i]; s_wstrb[i] = q_strb[i];
                    end else begin
                        s_arvalid[i] = 1; s_araddr[i] = q_addr[i];
                    end
                end
            end
        end
        chk("rnd_completed", n_done >= 300, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
